// File: rtl/pipe_sequencer.sv
// pipe_sequencer: sequencing controller for the two-stage pipeline.
// Produces fetch/vector-load enables, stage valid bits and the stage-2
// commit gate from the decode results (PC_load_en, HLT) and the external
// stall / halt / run controls, and counts retired instructions.
// Outputs are driven from registered state plus the current inputs; run
// only ever acts on the state register.
module pipe_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             PC_load_en,
    input  logic             HLT,
    input  logic             halt_req,
    input  logic             run,
    output logic             fetch_en,
    output logic             vec_load,
    output logic             s1_valid,
    output logic             s2_valid,
    output logic             s2_commit,
    output logic             halted,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_s1_valid;
    logic             r_s2_valid;
    logic             r_halt_pending;
    logic [CNT_W-1:0] r_retired_cnt;

    logic             w_adv;
    logic             w_fetch_en;
    logic             w_vec_load;
    logic             w_commit;
    logic             w_halted;
    logic             w_taken;
    logic             w_halting;
    logic             w_s1_nxt;
    logic             w_s2_nxt;
    logic             w_pend_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Wrapping increment of the retired-instruction counter.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] cnt);
        cnt_inc = cnt + CNT_W'(1);
    endfunction

    // Next-state, valid-bit and output decode for the sequencer FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_adv       = 1'b0;
        w_fetch_en  = 1'b0;
        w_vec_load  = 1'b0;
        w_commit    = 1'b0;
        w_halted    = 1'b0;
        w_taken     = 1'b0;
        w_halting   = 1'b0;
        w_s1_nxt    = r_s1_valid;
        w_s2_nxt    = r_s2_valid;
        w_pend_nxt  = r_halt_pending;

        case (r_state)
            ST_BOOT: begin
                // PC takes the start vector; stall has no effect here.
                w_vec_load  = 1'b1;
                w_state_nxt = ST_RUN;
                if (halt_req) begin
                    w_pend_nxt = 1'b1;
                end else begin
                    w_pend_nxt = r_halt_pending;
                end
            end

            ST_RUN: begin
                w_adv      = ~stall;
                w_fetch_en = w_adv;
                w_commit   = w_adv & r_s2_valid;
                w_taken    = w_commit & PC_load_en;
                w_halting  = w_adv & ((w_commit & HLT) | r_halt_pending | halt_req);
                if (w_halting) begin
                    // Stage 2 commits this cycle; everything younger is dropped.
                    w_state_nxt = ST_HALT;
                    w_s1_nxt    = 1'b0;
                    w_s2_nxt    = 1'b0;
                    w_pend_nxt  = 1'b0;
                end else if (w_adv) begin
                    // A taken branch squashes both already-fetched fall-through slots.
                    w_s2_nxt = r_s1_valid & ~w_taken;
                    w_s1_nxt = ~w_taken;
                end else begin
                    // Frozen: valids hold, a halt request waits for the next advance.
                    w_s1_nxt = r_s1_valid;
                    w_s2_nxt = r_s2_valid;
                    if (halt_req) begin
                        w_pend_nxt = 1'b1;
                    end else begin
                        w_pend_nxt = r_halt_pending;
                    end
                end
            end

            ST_HALT: begin
                // Pipeline is empty; halt requests are dropped while halted.
                w_halted   = 1'b1;
                w_s1_nxt   = 1'b0;
                w_s2_nxt   = 1'b0;
                w_pend_nxt = 1'b0;
                if (run) begin
                    w_state_nxt = ST_BOOT;
                end else begin
                    w_state_nxt = ST_HALT;
                end
            end

            default: begin
                // Unreachable encoding: recover through a clean boot.
                w_state_nxt = ST_BOOT;
                w_s1_nxt    = 1'b0;
                w_s2_nxt    = 1'b0;
                w_pend_nxt  = 1'b0;
            end
        endcase

        if (w_commit) begin
            w_cnt_nxt = cnt_inc(r_retired_cnt);
        end else begin
            w_cnt_nxt = r_retired_cnt;
        end
    end

    // State, valid bits, pending halt and retired counter; rst wins over all.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_BOOT;
            r_s1_valid     <= 1'b0;
            r_s2_valid     <= 1'b0;
            r_halt_pending <= 1'b0;
            r_retired_cnt  <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_s1_valid     <= w_s1_nxt;
            r_s2_valid     <= w_s2_nxt;
            r_halt_pending <= w_pend_nxt;
            r_retired_cnt  <= w_cnt_nxt;
        end
    end

    assign fetch_en    = w_fetch_en;
    assign vec_load    = w_vec_load;
    assign s1_valid    = r_s1_valid;
    assign s2_valid    = r_s2_valid;
    assign s2_commit   = w_commit;
    assign halted      = w_halted;
    assign retired_cnt = r_retired_cnt;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed testbench for pipe_sequencer. Cycle numbers count from the
// BOOT cycle (cycle 0) that follows each reset.
module tb_pipe_sequencer;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        PC_load_en;
    logic        HLT;
    logic        halt_req;
    logic        run;

    logic        fetch_en;
    logic        vec_load;
    logic        s1_valid;
    logic        s2_valid;
    logic        s2_commit;
    logic        halted;
    logic [15:0] retired_cnt;

    logic        fetch_en4;
    logic        vec_load4;
    logic        s1_valid4;
    logic        s2_valid4;
    logic        s2_commit4;
    logic        halted4;
    logic [3:0]  retired_cnt4;

    int n_checks;
    int n_pass;
    int cyc;

    pipe_sequencer #(.CNT_W(16)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .PC_load_en  (PC_load_en),
        .HLT         (HLT),
        .halt_req    (halt_req),
        .run         (run),
        .fetch_en    (fetch_en),
        .vec_load    (vec_load),
        .s1_valid    (s1_valid),
        .s2_valid    (s2_valid),
        .s2_commit   (s2_commit),
        .halted      (halted),
        .retired_cnt (retired_cnt)
    );

    pipe_sequencer #(.CNT_W(4)) u_dut4 (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .PC_load_en  (PC_load_en),
        .HLT         (HLT),
        .halt_req    (halt_req),
        .run         (run),
        .fetch_en    (fetch_en4),
        .vec_load    (vec_load4),
        .s1_valid    (s1_valid4),
        .s2_valid    (s2_valid4),
        .s2_commit   (s2_commit4),
        .halted      (halted4),
        .retired_cnt (retired_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @cyc %0d: got %0d, want %0d", tag, cyc, got, exp);
        end
    endtask

    // Reset, leaving the bench inside cycle 0 (BOOT) with inputs idle.
    task automatic do_reset();
        rst        = 1'b1;
        stall      = 1'b0;
        PC_load_en = 1'b0;
        HLT        = 1'b0;
        halt_req   = 1'b0;
        run        = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        #1;
    endtask

    // Advance to cycle n; pulse inputs drop each cycle, stall is held.
    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
            cyc++;
            halt_req   = 1'b0;
            run        = 1'b0;
            PC_load_en = 1'b0;
            HLT        = 1'b0;
        end
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;

        // Straight-line execution after reset.
        do_reset();
        chk("boot_vec",    32'(vec_load),    32'd1);
        chk("boot_fetch",  32'(fetch_en),    32'd0);
        chk("boot_commit", 32'(s2_commit),   32'd0);
        chk("boot_halted", 32'(halted),      32'd0);
        chk("boot_s1",     32'(s1_valid),    32'd0);
        chk("boot_s2",     32'(s2_valid),    32'd0);
        chk("boot_cnt",    32'(retired_cnt), 32'd0);
        goto(1);
        chk("c1_fetch", 32'(fetch_en), 32'd1);
        chk("c1_vec",   32'(vec_load), 32'd0);
        chk("c1_s1",    32'(s1_valid), 32'd0);
        goto(2);
        chk("c2_s1",     32'(s1_valid),  32'd1);
        chk("c2_s2",     32'(s2_valid),  32'd0);
        chk("c2_commit", 32'(s2_commit), 32'd0);
        for (int c = 3; c <= 7; c++) begin
            goto(c);
            chk("line_commit", 32'(s2_commit), 32'd1);
        end
        goto(8);
        chk("line_cnt", 32'(retired_cnt), 32'd5);
        run = 1'b1;
        #1;
        goto(9);
        chk("run_in_run_vec",    32'(vec_load),  32'd0);
        chk("run_in_run_halted", 32'(halted),    32'd0);
        chk("run_in_run_commit", 32'(s2_commit), 32'd1);

        // Taken jump committed at cycle 5.
        do_reset();
        goto(5);
        PC_load_en = 1'b1;
        #1;
        chk("jmp_commit", 32'(s2_commit), 32'd1);
        goto(6);
        chk("jmp_s2_c6",  32'(s2_valid), 32'd0);
        chk("jmp_s1_c6",  32'(s1_valid), 32'd0);
        chk("jmp_fetch",  32'(fetch_en), 32'd1);
        goto(7);
        chk("jmp_s2_c7",  32'(s2_valid), 32'd0);
        chk("jmp_s1_c7",  32'(s1_valid), 32'd1);
        goto(8);
        chk("jmp_target", 32'(s2_commit), 32'd1);
        goto(9);
        chk("jmp_cnt", 32'(retired_cnt), 32'd4);

        // Three-cycle stall with a valid stage-2 instruction at cycle 4.
        do_reset();
        goto(4);
        stall = 1'b1;
        #1;
        chk("stl_fetch_c4",  32'(fetch_en),    32'd0);
        chk("stl_commit_c4", 32'(s2_commit),   32'd0);
        chk("stl_s2_c4",     32'(s2_valid),    32'd1);
        chk("stl_cnt_c4",    32'(retired_cnt), 32'd1);
        goto(5);
        chk("stl_fetch_c5",  32'(fetch_en),  32'd0);
        chk("stl_s1_c5",     32'(s1_valid),  32'd1);
        goto(6);
        chk("stl_fetch_c6",  32'(fetch_en),  32'd0);
        chk("stl_commit_c6", 32'(s2_commit), 32'd0);
        goto(7);
        stall = 1'b0;
        #1;
        chk("stl_commit_c7", 32'(s2_commit),   32'd1);
        chk("stl_fetch_c7",  32'(fetch_en),    32'd1);
        chk("stl_cnt_c7",    32'(retired_cnt), 32'd1);
        goto(8);
        chk("stl_cnt_c8",    32'(retired_cnt), 32'd2);

        // HLT commit at cycle 6, resume with run at cycle 10.
        do_reset();
        goto(6);
        HLT = 1'b1;
        #1;
        chk("hlt_commit", 32'(s2_commit), 32'd1);
        goto(7);
        chk("hlt_halted_c7", 32'(halted),      32'd1);
        chk("hlt_fetch_c7",  32'(fetch_en),    32'd0);
        chk("hlt_commit_c7", 32'(s2_commit),   32'd0);
        chk("hlt_s1_c7",     32'(s1_valid),    32'd0);
        chk("hlt_s2_c7",     32'(s2_valid),    32'd0);
        chk("hlt_cnt_c7",    32'(retired_cnt), 32'd4);
        goto(9);
        chk("hlt_halted_c9", 32'(halted), 32'd1);
        goto(10);
        run = 1'b1;
        #1;
        chk("hlt_halted_c10", 32'(halted),   32'd1);
        chk("hlt_vec_c10",    32'(vec_load), 32'd0);
        goto(11);
        chk("res_vec_c11",    32'(vec_load), 32'd1);
        chk("res_halted_c11", 32'(halted),   32'd0);
        chk("res_fetch_c11",  32'(fetch_en), 32'd0);
        goto(12);
        chk("res_fetch_c12",  32'(fetch_en), 32'd1);
        goto(13);
        chk("res_commit_c13", 32'(s2_commit), 32'd0);
        goto(14);
        chk("res_commit_c14", 32'(s2_commit), 32'd1);
        goto(15);
        chk("res_cnt_c15", 32'(retired_cnt), 32'd5);

        // halt_req during stall, then run together with halt_req in HALT.
        do_reset();
        goto(5);
        stall    = 1'b1;
        halt_req = 1'b1;
        #1;
        chk("hreq_commit_c5", 32'(s2_commit), 32'd0);
        goto(6);
        chk("hreq_halted_c6", 32'(halted),   32'd0);
        chk("hreq_s2_c6",     32'(s2_valid), 32'd1);
        goto(7);
        stall = 1'b0;
        #1;
        chk("hreq_commit_c7", 32'(s2_commit), 32'd1);
        goto(8);
        chk("hreq_halted_c8", 32'(halted),      32'd1);
        chk("hreq_cnt_c8",    32'(retired_cnt), 32'd3);
        goto(9);
        run      = 1'b1;
        halt_req = 1'b1;
        #1;
        goto(10);
        chk("hreq_vec_c10",    32'(vec_load), 32'd1);
        goto(11);
        chk("hreq_fetch_c11",  32'(fetch_en), 32'd1);
        goto(12);
        chk("hreq_halted_c12", 32'(halted),   32'd0);
        chk("hreq_s1_c12",     32'(s1_valid), 32'd1);
        goto(13);
        chk("hreq_commit_c13", 32'(s2_commit), 32'd1);
        goto(14);
        chk("hreq_halted_c14", 32'(halted),      32'd0);
        chk("hreq_cnt_c14",    32'(retired_cnt), 32'd4);

        // halt_req during BOOT is remembered and honoured at the first advance.
        do_reset();
        halt_req = 1'b1;
        #1;
        chk("bhreq_vec_c0", 32'(vec_load), 32'd1);
        goto(1);
        chk("bhreq_fetch_c1",  32'(fetch_en), 32'd1);
        chk("bhreq_halted_c1", 32'(halted),   32'd0);
        goto(2);
        chk("bhreq_halted_c2", 32'(halted),      32'd1);
        chk("bhreq_s1_c2",     32'(s1_valid),    32'd0);
        chk("bhreq_cnt_c2",    32'(retired_cnt), 32'd0);

        // Simultaneous taken branch and HLT: commits, then halts.
        do_reset();
        goto(5);
        PC_load_en = 1'b1;
        HLT        = 1'b1;
        #1;
        chk("brhlt_commit_c5", 32'(s2_commit), 32'd1);
        goto(6);
        chk("brhlt_halted_c6", 32'(halted),      32'd1);
        chk("brhlt_cnt_c6",    32'(retired_cnt), 32'd3);

        // rst during a stalled taken branch.
        do_reset();
        goto(5);
        stall      = 1'b1;
        PC_load_en = 1'b1;
        #1;
        chk("rstbr_commit_c5", 32'(s2_commit), 32'd0);
        goto(6);
        stall      = 1'b1;
        PC_load_en = 1'b1;
        rst        = 1'b1;
        #1;
        goto(7);
        rst = 1'b0;
        #1;
        chk("rstbr_vec_c7",    32'(vec_load),    32'd1);
        chk("rstbr_s1_c7",     32'(s1_valid),    32'd0);
        chk("rstbr_s2_c7",     32'(s2_valid),    32'd0);
        chk("rstbr_cnt_c7",    32'(retired_cnt), 32'd0);
        chk("rstbr_commit_c7", 32'(s2_commit),   32'd0);
        goto(8);
        chk("rstbr_fetch_c8",  32'(fetch_en),    32'd0);
        stall = 1'b0;

        // Counter wrap on the 4-bit instance after 16 commits.
        do_reset();
        goto(18);
        chk("wrap_cnt4_c18",  32'(retired_cnt4), 32'd15);
        goto(19);
        chk("wrap_cnt4_c19",  32'(retired_cnt4), 32'd0);
        chk("wrap_cnt16_c19", 32'(retired_cnt),  32'd16);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
